// File: rtl/csc_pkg.sv
// Shared widths and types for the colour-space-conversion scheduler.
package csc_pkg;

  localparam int CSC_DATA_WIDTH = 8;
  localparam int CSC_FRAC_WIDTH = 8;

  // Width of one packed pixel {ch1,ch2,ch3} and of one packed result.
  localparam int PIX_W = 3 * CSC_DATA_WIDTH;
  localparam int RES_W = 3 * (CSC_DATA_WIDTH + CSC_FRAC_WIDTH);

  // Requester identifier: 0 or 1.
  typedef logic req_id_t;

  // One stage of the engine-tracking shift register.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  function automatic int pix_width(input int dw);
    return 3 * dw;
  endfunction

  function automatic int res_width(input int dw, input int fw);
    return 3 * (dw + fw);
  endfunction

endpackage

// File: rtl/csc_ofifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head word is visible on pop_data whenever empty is low.
module csc_ofifo
  import csc_pkg::*;
#(
  parameter int WIDTH = RES_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write on accepted push.
  // NOTE: the data array carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; simultaneous push and pop keeps count.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/csc_scheduler.sv
// Two-requester front end for a shared colour-space-conversion engine.
// Credit-based round-robin issue, tag pipeline matching the engine
// latency, and one FWFT result FIFO per requester.
module csc_scheduler
  import csc_pkg::*;
#(
  parameter int DATA_WIDTH  = CSC_DATA_WIDTH,
  parameter int FRAC_WIDTH  = CSC_FRAC_WIDTH,
  parameter int ENG_LAT     = 3,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    s0_valid,
  output logic                                    s0_ready,
  input  logic [3*DATA_WIDTH-1:0]                 s0_data,
  input  logic                                    s1_valid,
  output logic                                    s1_ready,
  input  logic [3*DATA_WIDTH-1:0]                 s1_data,
  output logic                                    eng_valid,
  output logic [3*DATA_WIDTH-1:0]                 eng_data,
  input  logic [3*(DATA_WIDTH+FRAC_WIDTH)-1:0]    eng_result,
  output logic                                    m0_valid,
  input  logic                                    m0_ready,
  output logic [3*(DATA_WIDTH+FRAC_WIDTH)-1:0]    m0_data,
  output logic                                    m1_valid,
  input  logic                                    m1_ready,
  output logic [3*(DATA_WIDTH+FRAC_WIDTH)-1:0]    m1_data,
  output logic                                    busy
);

  localparam int PW = pix_width(DATA_WIDTH);
  localparam int RW = res_width(DATA_WIDTH, FRAC_WIDTH);
  localparam int CW = $clog2(OFIFO_DEPTH) + 1;

  tag_t          tags [ENG_LAT+1];
  tag_t          out_tag;
  req_id_t       last_grant;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic          empty0;
  logic          empty1;
  logic          push0;
  logic          push1;
  logic          grant0;
  logic          grant1;
  logic          hs;
  logic          any_tag;
  int            infl0;
  int            infl1;
  int            credit0;
  int            credit1;

  // Credit accounting and round-robin arbitration among eligible requesters.
  // NOTE: every variable gets a default at the top so no latch is inferred.
  always_comb begin
    infl0   = 0;
    infl1   = 0;
    any_tag = 1'b0;
    for (int k = 0; k <= ENG_LAT; k++) begin
      if (tags[k].valid) begin
        any_tag = 1'b1;
        if (tags[k].id) infl1 = infl1 + 1;
        else            infl0 = infl0 + 1;
      end
    end
    credit0 = OFIFO_DEPTH - int'(cnt0) - infl0;
    credit1 = OFIFO_DEPTH - int'(cnt1) - infl1;
    grant0  = 1'b0;
    grant1  = 1'b0;
    if (rst_n) begin
      // last_grant==1 means requester 0 has priority on a tie.
      grant0 = s0_valid && (credit0 > 0) &&
               (!(s1_valid && (credit1 > 0)) || (last_grant == 1'b1));
      grant1 = s1_valid && (credit1 > 0) &&
               (!(s0_valid && (credit0 > 0)) || (last_grant == 1'b0));
    end
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;
  assign hs       = grant0 || grant1;

  // Issue register, grant pointer and tag pipeline aligned to the engine.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_valid  <= 1'b0;
      eng_data   <= '0;
      last_grant <= 1'b1;
      for (int k = 0; k <= ENG_LAT; k++) tags[k] <= '0;
    end else begin
      eng_valid <= hs;
      if (hs) begin
        eng_data   <= grant1 ? s1_data : s0_data;
        last_grant <= grant1;
      end
      tags[0] <= '{valid: hs, id: grant1};
      for (int k = 1; k <= ENG_LAT; k++) tags[k] <= tags[k-1];
    end
  end

  // The oldest tag lines up with eng_result for the operand it describes.
  assign out_tag = tags[ENG_LAT];
  assign push0   = out_tag.valid && (out_tag.id == 1'b0);
  assign push1   = out_tag.valid && (out_tag.id == 1'b1);

  csc_ofifo #(.WIDTH(RW), .DEPTH(OFIFO_DEPTH)) u_ofifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (eng_result),
    .pop       (m0_ready),
    .pop_data  (m0_data),
    .empty     (empty0),
    .count     (cnt0)
  );

  csc_ofifo #(.WIDTH(RW), .DEPTH(OFIFO_DEPTH)) u_ofifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (eng_result),
    .pop       (m1_ready),
    .pop_data  (m1_data),
    .empty     (empty1),
    .count     (cnt1)
  );

  assign m0_valid = !empty0;
  assign m1_valid = !empty1;
  assign busy     = eng_valid || any_tag || !empty0 || !empty1;

  // Operand width is fixed by the package helpers; keep it tied to the port.
  logic [PW-1:0] unused_pw;
  assign unused_pw = eng_data;

endmodule

// File: tb/tb_csc_scheduler.sv
// Directed self-checking bench for csc_scheduler with a 3-cycle engine model.
module tb_csc_scheduler;

  localparam int PW = 24;
  localparam int RW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s0_valid = 1'b0, s1_valid = 1'b0;
  logic          s0_ready, s1_ready;
  logic [PW-1:0] s0_data = '0, s1_data = '0;
  logic          eng_valid;
  logic [PW-1:0] eng_data;
  logic [RW-1:0] eng_result;
  logic          m0_valid, m1_valid;
  logic          m0_ready = 1'b1, m1_ready = 1'b1;
  logic [RW-1:0] m0_data, m1_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int k0 = 0, k1 = 0;

  // Monitor logs
  int            grant_log[$];
  logic [RW-1:0] exp0[$], exp1[$], out0[$], out1[$];
  int            outc0[$], outc1[$], ev_cyc[$];
  logic [PW-1:0] ev_data[$];
  int            both_hs = 0, m1_seen = 0, ovf = 0;

  csc_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_result(eng_result),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: out1={ch1,ch2}, out2={ch2,ch3}, out3={ch3,ch1}.
  function automatic logic [RW-1:0] eng_model(input logic [PW-1:0] p);
    return {p[23:16], p[15:8], p[15:8], p[7:0], p[7:0], p[23:16]};
  endfunction

  logic [RW-1:0] epipe [3];
  always @(posedge clk) begin
    epipe[0] <= eng_model(eng_data);
    epipe[1] <= epipe[0];
    epipe[2] <= epipe[1];
  end
  assign eng_result = epipe[2];

  function automatic logic [PW-1:0] pix0(input int k);
    return {8'(k), 8'(k + 64), 8'h0A};
  endfunction
  function automatic logic [PW-1:0] pix1(input int k);
    return {8'(k + 128), 8'h55, 8'(k * 3)};
  endfunction

  // Mid-cycle monitor: inputs change just after posedge, so values here hold at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s0_valid && s0_ready) begin grant_log.push_back(0); exp0.push_back(eng_model(s0_data)); end
      if (s1_valid && s1_ready) begin grant_log.push_back(1); exp1.push_back(eng_model(s1_data)); end
      if (s0_valid && s0_ready && s1_valid && s1_ready) both_hs++;
      if (m0_valid && m0_ready) begin out0.push_back(m0_data); outc0.push_back(cyc); end
      if (m1_valid && m1_ready) begin out1.push_back(m1_data); outc1.push_back(cyc); end
      if (eng_valid) begin ev_cyc.push_back(cyc); ev_data.push_back(eng_data); end
      if (m1_valid) m1_seen++;
      if (dut.u_ofifo0.push && dut.u_ofifo0.full) ovf++;
      if (dut.u_ofifo1.push && dut.u_ofifo1.full) ovf++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); exp0.delete(); exp1.delete(); out0.delete(); out1.delete();
    outc0.delete(); outc1.delete(); ev_cyc.delete(); ev_data.delete();
    both_hs = 0; m1_seen = 0;
  endtask

  // Drive n cycles with whatever valids are set, advancing data on each handshake.
  task automatic run_cycles(input int n);
    logic h0, h1;
    for (int i = 0; i < n; i++) begin
      s0_data = pix0(k0);
      s1_data = pix1(k1);
      #1;
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      tick();
      if (h0) k0++;
      if (h1) k1++;
    end
  endtask

  task automatic drain(input string name);
    int i;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    i = 0;
    while (busy && i < 60) begin tick(); i++; end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: busy=%b required 0", name, busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = 24'h123456; s1_data = 24'h654321;
    tick(); tick(); tick();
    n_checks++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s0_ready: got %b required 0", s0_ready); end
    n_checks++; if (s1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s1_ready: got %b required 0", s1_ready); end
    n_checks++; if (eng_valid !== 1'b0) begin n_fail++; $display("FAIL reset_eng_valid: got %b required 0", eng_valid); end
    n_checks++; if (eng_data !== 24'h0) begin n_fail++; $display("FAIL reset_eng_data: got %h required 0", eng_data); end
    n_checks++; if ({m0_valid, m1_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_m_valid: got %b required 00", {m0_valid, m1_valid}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL reset_first_tie: ready={s0,s1}=%b required 10", {s0_ready, s1_ready});
    end
    tick();
    drain("reset");
  endtask

  task automatic test_single();
    int hs_cyc, i;
    logic rdy;
    clear_logs();
    s0_data = {8'd255, 8'd128, 8'd64};
    s0_valid = 1'b1; s1_valid = 1'b0;
    #1;
    rdy = s0_ready;
    hs_cyc = cyc;
    tick();
    s0_valid = 1'b0;
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", rdy); end
    i = 0;
    while (out0.size() == 0 && i < 20) begin tick(); i++; end
    drain("single");
    n_checks++;
    if (out0.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d results required 1", out0.size()); end
    else begin
      n_checks++;
      if (outc0[0] - hs_cyc != 5) begin n_fail++; $display("FAIL single_latency: got %0d cycles required 5", outc0[0] - hs_cyc); end
      n_checks++;
      if (out0[0] !== 48'hFF80_8040_40FF) begin n_fail++; $display("FAIL single_data: got %h required ff80804040ff", out0[0]); end
    end
    n_checks++;
    if (ev_cyc.size() != 1 || ev_cyc[0] != hs_cyc + 1 || ev_data[0] !== 24'hFF8040) begin
      n_fail++; $display("FAIL single_issue: %0d issue cycles, first at offset %0d data %h, required 1 at offset 1 data ff8040",
                         ev_cyc.size(), (ev_cyc.size() > 0) ? ev_cyc[0] - hs_cyc : -1, (ev_data.size() > 0) ? ev_data[0] : 24'h0);
    end
    n_checks++; if (m1_seen != 0) begin n_fail++; $display("FAIL single_m1_quiet: m1_valid high %0d cycles required 0", m1_seen); end
  endtask

  task automatic test_contention();
    int repeats, bad;
    clear_logs();
    m0_ready = 1'b1; m1_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    run_cycles(12);
    drain("contention");
    repeats = 0;
    for (int i = 1; i < grant_log.size(); i++) if (grant_log[i] == grant_log[i-1]) repeats++;
    n_checks++;
    if (grant_log.size() != 12 || repeats != 0) begin
      n_fail++; $display("FAIL contention_alternate: %0d grants with %0d repeats, required 12 with 0", grant_log.size(), repeats);
    end
    n_checks++;
    if (grant_log.size() == 0 || grant_log[0] != 1) begin
      n_fail++; $display("FAIL contention_first: got first grant %0d required 1", (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    n_checks++;
    if (ev_cyc.size() != 12 || ev_cyc[ev_cyc.size()-1] - ev_cyc[0] != 11) begin
      n_fail++; $display("FAIL contention_eng_every_cycle: %0d issue cycles, required 12 consecutive", ev_cyc.size());
    end
    n_checks++; if (both_hs != 0) begin n_fail++; $display("FAIL contention_one_per_cycle: got %0d double grants required 0", both_hs); end
    bad = 0;
    for (int i = 0; i < exp0.size() && i < out0.size(); i++) if (out0[i] !== exp0[i]) bad++;
    for (int i = 0; i < exp1.size() && i < out1.size(); i++) if (out1[i] !== exp1[i]) bad++;
    n_checks++;
    if (out0.size() != 6 || out1.size() != 6 || exp0.size() != 6 || bad != 0) begin
      n_fail++; $display("FAIL contention_data: got %0d/%0d results with %0d wrong, required 6/6 with 0", out0.size(), out1.size(), bad);
    end
  endtask

  task automatic test_backpressure();
    int n0, n1, last0;
    clear_logs();
    m0_ready = 1'b0; m1_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1;
    run_cycles(30);
    n0 = 0; n1 = 0; last0 = -1;
    for (int i = 0; i < grant_log.size(); i++) begin
      if (grant_log[i] == 0) begin n0++; last0 = i; end
      else n1++;
    end
    n_checks++; if (n0 != 4) begin n_fail++; $display("FAIL backpressure_s0_count: got %0d handshakes required 4", n0); end
    n_checks++; if (last0 >= 8) begin n_fail++; $display("FAIL backpressure_s0_stop: last s0 grant at index %0d required below 8", last0); end
    n_checks++; if (n1 < 16) begin n_fail++; $display("FAIL backpressure_s1_progress: got %0d s1 handshakes required at least 16", n1); end
    #1;
    n_checks++;
    if ({s0_ready, m0_valid} !== 2'b01) begin
      n_fail++; $display("FAIL backpressure_hold: {s0_ready,m0_valid}=%b required 01", {s0_ready, m0_valid});
    end
    n_checks++; if (out0.size() != 0) begin n_fail++; $display("FAIL backpressure_no_pop: got %0d s0 results required 0", out0.size()); end
  endtask

  task automatic test_release();
    int r, n0, bad;
    tick();
    m0_ready = 1'b1;
    r = cyc;
    run_cycles(20);
    drain("release");
    n_checks++;
    if (outc0.size() < 4 || outc0[0] != r || outc0[3] != r + 3) begin
      n_fail++; $display("FAIL release_consecutive: first pop offset %0d, fourth offset %0d, required 0 and 3",
                         (outc0.size() > 0) ? outc0[0] - r : -1, (outc0.size() > 3) ? outc0[3] - r : -1);
    end
    n0 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 0) n0++;
    n_checks++; if (n0 <= 4) begin n_fail++; $display("FAIL release_resume: got %0d s0 handshakes required more than 4", n0); end
    bad = 0;
    for (int i = 0; i < exp0.size() && i < out0.size(); i++) if (out0[i] !== exp0[i]) bad++;
    n_checks++;
    if (out0.size() != exp0.size() || bad != 0) begin
      n_fail++; $display("FAIL release_data0: got %0d results (%0d wrong), required %0d (0 wrong)", out0.size(), bad, exp0.size());
    end
    bad = 0;
    for (int i = 0; i < exp1.size() && i < out1.size(); i++) if (out1[i] !== exp1[i]) bad++;
    n_checks++;
    if (out1.size() != exp1.size() || bad != 0) begin
      n_fail++; $display("FAIL release_data1: got %0d results (%0d wrong), required %0d (0 wrong)", out1.size(), bad, exp1.size());
    end
  endtask

  task automatic test_reset_midflight();
    clear_logs();
    m0_ready = 1'b1; m1_ready = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b0;
    run_cycles(3);
    s0_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || grant_log.size() != 3) begin
      n_fail++; $display("FAIL midflight_setup: busy=%b with %0d issued, required 1 with 3", busy, grant_log.size());
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({busy, m0_valid, m1_valid, eng_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL midflight_cleared: {busy,m0_valid,m1_valid,eng_valid}=%b required 0000", {busy, m0_valid, m1_valid, eng_valid});
    end
    clear_logs();
    repeat (12) tick();
    n_checks++;
    if (out0.size() + out1.size() != 0) begin
      n_fail++; $display("FAIL midflight_stale: got %0d results after reset required 0", out0.size() + out1.size());
    end
    s0_data = 24'hA1B2C3; s1_data = 24'h0F0E0D;
    s0_valid = 1'b1; s1_valid = 1'b1;
    #1;
    n_checks++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL midflight_tie: ready={s0,s1}=%b required 10", {s0_ready, s1_ready});
    end
    tick();
    drain("midflight");
    n_checks++;
    if (out0.size() != 1 || out1.size() != 0 || out0[0] !== 48'hA1B2_B2C3_C3A1) begin
      n_fail++; $display("FAIL midflight_fresh: got %0d/%0d results first %h, required 1/0 first a1b2b2c3c3a1",
                         out0.size(), out1.size(), (out0.size() > 0) ? out0[0] : 48'h0);
    end
  endtask

  task automatic test_no_overflow();
    n_checks++;
    if (ovf != 0) begin n_fail++; $display("FAIL no_push_when_full: got %0d overflow pushes required 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_release();
    test_reset_midflight();
    test_no_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csc_scheduler.md
CSC_SCHEDULER -- requirements
Module: csc_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of each input colour channel.
REQ-002 Parameter FRAC_WIDTH, default 8, is the number of fractional bits of each signed fixed-point result channel.
REQ-003 Parameter ENG_LAT, default 3, is the engine latency in cycles, with 0 meaning combinational.
REQ-004 Parameter OFIFO_DEPTH, default 4, is the output FIFO depth per requester, a power of two of at least 2.
REQ-005 Port clk, input, 1 bit, is the single clock; all logic is clocked on its rising edge.
REQ-006 Port rst_n, input, 1 bit, is the reset: synchronous, active-low.
REQ-007 Ports s0_valid and s1_valid, input, 1 bit each, are the requester pixel-valid signals.
REQ-008 Ports s0_ready and s1_ready, output, 1 bit each, are asserted when that requester's pixel is accepted.
REQ-009 Ports s0_data and s1_data, input, 3*DATA_WIDTH bits each, carry the pixel as {ch1,ch2,ch3} with ch1 in the MSBs.
REQ-010 Port eng_valid, output, 1 bit, marks a pixel issued to the shared conversion engine.
REQ-011 Port eng_data, output, 3*DATA_WIDTH bits, is the engine operand, unpacked to its data_in1..3.
REQ-012 Port eng_result, input, 3*(DATA_WIDTH+FRAC_WIDTH) bits, is the engine's data_out1..3 for the operand presented ENG_LAT cycles earlier.
REQ-013 Ports m0_valid and m1_valid, output, 1 bit each, are the per-requester result-valid signals.
REQ-014 Ports m0_ready and m1_ready, input, 1 bit each, are the per-requester result-accept signals.
REQ-015 Ports m0_data and m1_data, output, 3*(DATA_WIDTH+FRAC_WIDTH) bits each, carry the converted result.
REQ-016 Port busy, output, 1 bit, is high while any pixel is issued, in flight or buffered.

Function
REQ-017 The block SHALL accept at most one pixel per cycle in total; a handshake is s_i_valid && s_i_ready.
REQ-018 Requester i SHALL be eligible when s_i_valid=1 and credit_i>0, where credit_i = OFIFO_DEPTH - fifo_count_i - inflight_i.
REQ-019 Arbitration SHALL be round-robin: if both requesters are eligible, the one not granted last wins; if only one is eligible, it wins; the last-grant pointer updates only on a handshake.
REQ-020 s_i_ready SHALL be combinational, high only for the winner, and may depend on both s_valid inputs.
REQ-021 A handshake in cycle t SHALL register eng_valid=1 and eng_data=s_i_data in cycle t+1; eng_valid SHALL be 0 otherwise.
REQ-022 A tag shift register {valid,id} of ENG_LAT+1 stages SHALL track each issue, and eng_result SHALL be pushed into output FIFO id when the tag emerges.
REQ-023 Handshake-to-m_valid latency SHALL be ENG_LAT+2 cycles (5 at default); sustained aggregate throughput SHALL be 1 pixel per cycle.
REQ-024 Output FIFOs SHALL be first-word-fall-through: m_i_valid = not empty; pop on m_i_valid && m_i_ready; per-requester order preserved.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged; the credit rule SHALL make push-when-full impossible, and the bench asserts this.
REQ-026 Backpressure on one requester SHALL NOT stall the other.
REQ-027 busy SHALL equal eng_valid OR any tag valid OR any FIFO non-empty.

Reset
REQ-028 While rst_n=0 at a clock edge: s*_ready=0, eng_valid=0, eng_data=0, all tags invalid, FIFOs empty, m*_valid=0, busy=0, and the pointer set so requester 0 wins the first tie.
REQ-029 Reset mid-operation SHALL discard all in-flight and buffered pixels; none SHALL appear on m* after reset.

Structure
REQ-030 Package csc_pkg SHALL hold DATA_WIDTH/FRAC_WIDTH defaults, the derived PIX_W=3*DATA_WIDTH and RES_W=3*(DATA_WIDTH+FRAC_WIDTH), and the 1-bit requester-id type.
REQ-031 Sub-module csc_ofifo (synchronous FWFT FIFO with count output) SHALL be instantiated once per requester.

Verification
REQ-032 Single pixel: s0_data={8'd255,8'd128,8'd64}, engine model with ENG_LAT=3 -> m0_valid exactly 5 cycles after the handshake, data matches the model, m1_valid stays 0.
REQ-033 Contention: s0 and s1 valid continuously, m*_ready=1 -> grants alternate 0,1,0,1 and eng_valid is high every cycle.
REQ-034 Backpressure: m0_ready=0 and both s valid -> exactly 4 s0 handshakes then s0_ready=0 permanently; s1 takes every cycle.
REQ-035 Release: after REQ-034, raise m0_ready -> 4 s0 results in issue order on consecutive cycles, s0 issue resumes, no loss or duplication.
REQ-036 Reset mid-flight: rst_n=0 for 1 cycle with 3 pixels in flight -> next cycle busy=0 and m*_valid=0, no stale results ever emitted.
